sap1_pio_regs: RTL and testbench
================================

# sap1_pio_regs

PIO target for the SAP1 subsystem. It sits directly downstream of the host bridge and consumes its 16-bit PIO command stream. It provides an ID, control, status, scratch and error-count register set, plus a 16-entry window onto the SAP1 program RAM. It returns read data to the bridge through a fixed-latency, fully pipelined read path.

## Interface
Parameters:
- ID_VALUE, 32'h5A50_0001, value returned by the ID register.
- RAM_DEPTH, 16, program RAM entries (fixed 16; index is addr[5:2]).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- pio_addr  in  16  byte address of command.
- pio_data_w  in  32  write data.
- pio_rw  in  1  1 = read, 0 = write.
- pio_cmd_vld  in  1  one command per high cycle.
- pio_rd_vld  out  1  read response valid (1-cycle pulse).
- pio_data_r  out  32  read response data.
- cpu_run  out  1  CTRL.run.
- cpu_step  out  1  single-cycle step pulse.
- cpu_reset  out  1  CTRL.cpu_reset.
- cpu_halted  in  1  SAP1 halt status.
- cpu_out  in  8  SAP1 output register.
- ram_re  out  1  RAM read enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  4  RAM index.
- ram_wdata  out  8  RAM write data.
- ram_rdata  in  8  RAM read data, valid the cycle after ram_re.

## Operation
- Address map: accesses with addr[1:0] != 0 are unmapped.
  - 0x0000 ID, RO.
  - 0x0004 CTRL, RW: bit0 run, bit1 step (write-only pulse, reads 0), bit2 cpu_reset.
  - 0x0008 STATUS, RO: bit0 cpu_halted, [15:8] cpu_out, others 0.
  - 0x000C SCRATCH, RW 32-bit.
  - 0x0010 ERR, [7:0] count: any write clears it; reads return it.
  - 0x0100–0x013C RAM window: index addr[5:2]; write uses data_w[7:0]; read returns {24'h0, ram_rdata}.
  - Any other address is unmapped.
- Unmapped read: returns 32'hDEAD_BEEF with normal pio_rd_vld timing; ERR increments.
- Unmapped write: dropped; ERR increments.
- Write to ID or STATUS: dropped; ERR increments.
- RAM write while CTRL.run=1: ram_we held 0; ERR increments.
- ERR saturates at 8'hFF.
- If a clearing write to ERR and an error event occur in the same cycle, the clear wins (ERR=0).
- cpu_step:
  - A CTRL write with bit1=1 while run=0, both before and after the write, gives cpu_step=1 for exactly one cycle.
  - A CTRL write that sets run=1 and bit1=1 together produces no step.
- Writes are not acknowledged.
- Every read, mapped or not, produces exactly one pio_rd_vld pulse.

## Timing
- Reset values:
  - pio_rd_vld=0, pio_data_r=0.
  - cpu_run=0, cpu_step=0, cpu_reset=1 (SAP1 held in reset until software clears it).
  - ram_re=0, ram_we=0, ram_addr=0, ram_wdata=0.
  - SCRATCH=0, ERR=0.
- RAM port signals are combinational from the PIO inputs in command cycle T.
  - ram_re = vld & rw & in-window.
  - ram_we = vld & ~rw & in-window & ~run.
  - A RAM write in T is visible to a read issued in T+1.
- Register writes take effect at the end of T:
  - CTRL outputs change in T+1.
  - cpu_step is high in T+1 only.
- Read issued in T:
  - register and STATUS values are sampled in T (status is a snapshot at T);
  - ram_rdata is sampled in T+1;
  - pio_rd_vld=1 and pio_data_r valid in T+2.
  - Fixed latency is 2 cycles for every read.
- Back-to-back commands are accepted every cycle; responses come out in order, one per read, with no bubbles.
- A write in T followed by a read of the same register in T+1 returns the new value.
- pio_data_r holds its last value when pio_rd_vld=0.
- Reset asserted mid-flight:
  - in-flight reads are discarded;
  - pio_rd_vld=0 from the cycle after reset is sampled;
  - no response is produced for reads issued before reset.

## Test plan
- Reset, then read 0x0000, 0x0004, 0x0010 in consecutive cycles -> three rd_vld pulses at T+2, T+3, T+4 with data 32'h5A50_0001, 32'h4, 32'h0; cpu_reset=1.
- Write 0x0004=0x0; write 0x0004=0x2; read 0x0004 -> cpu_step high exactly one cycle after the second write, cpu_reset=0, read returns 32'h0.
- Write 0x0108=0xAB, then read 0x0108 in the next cycle -> ram_we at index 2, read returns 32'h0000_00AB at T+2.
- Write 0x0004=0x1 (run), then write 0x0100=0x55 -> ram_we stays 0; ERR read returns 1; write 0x0010 -> ERR reads 0.
- 300 unmapped writes to 0x2000 -> ERR=8'hFF (saturated); read 0x0003 -> 32'hDEAD_BEEF with rd_vld at T+2.
- Drive cpu_halted=1 and cpu_out=0x3C, read 0x0008; assert reset in T+1 -> no rd_vld; after release, re-read -> 32'h0000_3C01.

Source files
------------

// File: rtl/sap1_pio_regs.sv
// PIO register target for the SAP1 subsystem: ID/CTRL/STATUS/SCRATCH/ERR
// registers plus a 16-entry program RAM window. Every read returns on a
// fixed two-cycle pipeline.
module sap1_pio_regs #(
    parameter logic [31:0] ID_VALUE  = 32'h5A50_0001,
    parameter int unsigned RAM_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pio_addr,
    input  logic [31:0] pio_data_w,
    input  logic        pio_rw,
    input  logic        pio_cmd_vld,
    output logic        pio_rd_vld,
    output logic [31:0] pio_data_r,
    output logic        cpu_run,
    output logic        cpu_step,
    output logic        cpu_reset,
    input  logic        cpu_halted,
    input  logic [7:0]  cpu_out,
    output logic        ram_re,
    output logic        ram_we,
    output logic [3:0]  ram_addr,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata
);

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ERR_W    = 8;
    localparam logic [31:0] UNMAPPED = 32'hDEAD_BEEF;

    logic              cmd;
    logic              is_rd;
    logic              is_wr;
    logic              aligned;
    logic              hit_id;
    logic              hit_ctrl;
    logic              hit_stat;
    logic              hit_scr;
    logic              hit_err;
    logic              hit_win;
    logic              mapped;
    logic              err_ev;
    logic [DATA_W-1:0] rd_word;

    logic [DATA_W-1:0] scratch;
    logic [ERR_W-1:0]  err_cnt;

    logic              s1_vld;
    logic              s1_ram;
    logic [DATA_W-1:0] s1_data;

    // Address decode, error detection and read-data selection for cycle T
    always_comb begin
        cmd      = pio_cmd_vld & ~reset;
        is_rd    = cmd & pio_rw;
        is_wr    = cmd & ~pio_rw;
        aligned  = (pio_addr[1:0] == 2'b00);
        hit_id   = (pio_addr == 16'h0000);
        hit_ctrl = (pio_addr == 16'h0004);
        hit_stat = (pio_addr == 16'h0008);
        hit_scr  = (pio_addr == 16'h000C);
        hit_err  = (pio_addr == 16'h0010);
        hit_win  = aligned && (pio_addr[15:8] == 8'h01)
                   && (pio_addr[7:2] < 6'(RAM_DEPTH));
        mapped   = hit_id | hit_ctrl | hit_stat | hit_scr | hit_err | hit_win;
        err_ev   = cmd & (~mapped
                          | (~pio_rw & (hit_id | hit_stat))
                          | (~pio_rw & hit_win & cpu_run));
        rd_word  = UNMAPPED;
        if (hit_id)   rd_word = ID_VALUE;
        if (hit_ctrl) rd_word = {29'd0, cpu_reset, 1'b0, cpu_run};
        if (hit_stat) rd_word = {16'd0, cpu_out, 7'd0, cpu_halted};
        if (hit_scr)  rd_word = scratch;
        if (hit_err)  rd_word = {24'd0, err_cnt};
        if (hit_win)  rd_word = 32'd0;
    end

    // RAM port is driven straight from the command in its own cycle
    always_comb begin
        ram_re    = is_rd & hit_win;
        ram_we    = is_wr & hit_win & ~cpu_run;
        ram_addr  = 4'd0;
        ram_wdata = 8'd0;
        if (cmd && hit_win) begin
            ram_addr  = pio_addr[5:2];
            ram_wdata = pio_data_w[7:0];
        end
    end

    // Control, scratch and saturating error-count registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_run   <= 1'b0;
            cpu_step  <= 1'b0;
            cpu_reset <= 1'b1;
            scratch   <= '0;
            err_cnt   <= '0;
        end else begin
            cpu_step <= 1'b0;
            if (is_wr && hit_ctrl) begin
                cpu_run   <= pio_data_w[0];
                cpu_reset <= pio_data_w[2];
                // Step only when the CPU stays stopped across the write
                cpu_step  <= pio_data_w[1] & ~pio_data_w[0] & ~cpu_run;
            end
            if (is_wr && hit_scr) begin
                scratch <= pio_data_w;
            end
            // A clearing write beats a coincident error event
            if (is_wr && hit_err) begin
                err_cnt <= '0;
            end else if (err_ev && (err_cnt != {ERR_W{1'b1}})) begin
                err_cnt <= err_cnt + ERR_W'(1);
            end
        end
    end

    // Two-stage read pipeline; RAM data joins in stage one
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld     <= 1'b0;
            s1_ram     <= 1'b0;
            s1_data    <= '0;
            pio_rd_vld <= 1'b0;
            pio_data_r <= '0;
        end else begin
            s1_vld     <= is_rd;
            s1_ram     <= is_rd & hit_win;
            if (is_rd) begin
                s1_data <= rd_word;
            end
            pio_rd_vld <= s1_vld;
            if (s1_vld) begin
                pio_data_r <= s1_ram ? {24'd0, ram_rdata} : s1_data;
            end
        end
    end

endmodule

// File: tb/tb_sap1_pio_regs.sv
// Self-checking bench for sap1_pio_regs: expected read data is queued with
// its due cycle at issue time and compared when pio_rd_vld appears.
module tb_sap1_pio_regs;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pio_addr;
    logic [31:0] pio_data_w;
    logic        pio_rw;
    logic        pio_cmd_vld;
    logic        pio_rd_vld;
    logic [31:0] pio_data_r;
    logic        cpu_run;
    logic        cpu_step;
    logic        cpu_reset;
    logic        cpu_halted;
    logic [7:0]  cpu_out;
    logic        ram_re;
    logic        ram_we;
    logic [3:0]  ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic        last_we;
    logic [3:0]  last_addr;
    logic [7:0]  last_wdata;
    logic [7:0]  mem [16];

    sap1_pio_regs dut (
        .clk        (clk),
        .reset      (reset),
        .pio_addr   (pio_addr),
        .pio_data_w (pio_data_w),
        .pio_rw     (pio_rw),
        .pio_cmd_vld(pio_cmd_vld),
        .pio_rd_vld (pio_rd_vld),
        .pio_data_r (pio_data_r),
        .cpu_run    (cpu_run),
        .cpu_step   (cpu_step),
        .cpu_reset  (cpu_reset),
        .cpu_halted (cpu_halted),
        .cpu_out    (cpu_out),
        .ram_re     (ram_re),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Program RAM stand-in: registered read, write-first visibility next cycle
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Response monitor, sampling mid-cycle
    always @(negedge clk) begin
        logic exp_vld;
        exp_t e;
        exp_vld = (sb_q.size() > 0) && (sb_q[0].due == cyc);
        if (pio_rd_vld === 1'b1 || exp_vld) begin
            check("rd_vld", 32'(pio_rd_vld), 32'(exp_vld));
            if (exp_vld) begin
                e = sb_q.pop_front();
                if (pio_rd_vld === 1'b1) check("rd_data", pio_data_r, e.data);
            end
        end
        if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
            e = sb_q.pop_front();
            check("rd_late", 32'(1), 32'(0));
        end
    end

    // Issue one command for one cycle; capture combinational RAM port mid-cycle
    task automatic do_cmd(input logic [15:0] a, input logic rw,
                          input logic [31:0] wd, input logic [31:0] exp);
        exp_t e;
        pio_addr    = a;
        pio_rw      = rw;
        pio_data_w  = wd;
        pio_cmd_vld = 1'b1;
        if (rw) begin
            e.data = exp;
            e.due  = cyc + 2;
            sb_q.push_back(e);
        end
        #1;
        last_we    = ram_we;
        last_addr  = ram_addr;
        last_wdata = ram_wdata;
        @(posedge clk);
        #1;
        pio_cmd_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset       = 1'b1;
        pio_addr    = '0;
        pio_data_w  = '0;
        pio_rw      = 1'b0;
        pio_cmd_vld = 1'b0;
        cpu_halted  = 1'b0;
        cpu_out     = 8'h00;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        idle(3);
        check("rst_rd_vld", 32'(pio_rd_vld), 32'(0));
        check("rst_data_r", pio_data_r, 32'h0);
        check("rst_run", 32'(cpu_run), 32'(0));
        check("rst_step", 32'(cpu_step), 32'(0));
        check("rst_cpu_reset", 32'(cpu_reset), 32'(1));
        check("rst_ram_we", 32'(ram_we), 32'(0));
        reset = 1'b0;
        idle(1);

        // Back-to-back register reads after reset
        do_cmd(16'h0000, 1'b1, 32'h0, 32'h5A50_0001);
        do_cmd(16'h0004, 1'b1, 32'h0, 32'h0000_0004);
        do_cmd(16'h0010, 1'b1, 32'h0, 32'h0000_0000);
        check("cpu_reset_held", 32'(cpu_reset), 32'(1));
        idle(3);

        // Step pulse from a stopped CPU
        do_cmd(16'h0004, 1'b0, 32'h0, 32'h0);
        check("step_idle", 32'(cpu_step), 32'(0));
        do_cmd(16'h0004, 1'b0, 32'h2, 32'h0);
        check("step_pulse", 32'(cpu_step), 32'(1));
        check("cpu_reset_clr", 32'(cpu_reset), 32'(0));
        do_cmd(16'h0004, 1'b1, 32'h0, 32'h0000_0000);
        check("step_one_cycle", 32'(cpu_step), 32'(0));
        idle(3);

        // Scratch write then immediate read-back
        do_cmd(16'h000C, 1'b0, 32'hCAFE_1234, 32'h0);
        do_cmd(16'h000C, 1'b1, 32'h0, 32'hCAFE_1234);
        idle(3);

        // RAM window write then read in the next cycle
        do_cmd(16'h0108, 1'b0, 32'h0000_00AB, 32'h0);
        check("ram_we", 32'(last_we), 32'(1));
        check("ram_addr", 32'(last_addr), 32'(2));
        check("ram_wdata", 32'(last_wdata), 32'hAB);
        do_cmd(16'h0108, 1'b1, 32'h0, 32'h0000_00AB);
        idle(3);

        // Run and step together: no step
        do_cmd(16'h0004, 1'b0, 32'h3, 32'h0);
        check("no_step_with_run", 32'(cpu_step), 32'(0));
        check("run_set", 32'(cpu_run), 32'(1));

        // Errors: RAM write while running, write to ID; then clear
        do_cmd(16'h0100, 1'b0, 32'h55, 32'h0);
        check("ram_we_blocked", 32'(last_we), 32'(0));
        do_cmd(16'h0000, 1'b0, 32'hFFFF_FFFF, 32'h0);
        do_cmd(16'h0000, 1'b1, 32'h0, 32'h5A50_0001);
        do_cmd(16'h0010, 1'b1, 32'h0, 32'h0000_0002);
        do_cmd(16'h0010, 1'b0, 32'h0, 32'h0);
        do_cmd(16'h0010, 1'b1, 32'h0, 32'h0000_0000);
        do_cmd(16'h0100, 1'b1, 32'h0, 32'h0000_0000);
        idle(3);

        // Saturation, then unmapped misaligned read
        for (int i = 0; i < 300; i++) do_cmd(16'h2000, 1'b0, 32'(i), 32'h0);
        do_cmd(16'h0010, 1'b1, 32'h0, 32'h0000_00FF);
        do_cmd(16'h0003, 1'b1, 32'h0, 32'hDEAD_BEEF);
        do_cmd(16'h0140, 1'b1, 32'h0, 32'hDEAD_BEEF);
        idle(3);

        // Status read killed by reset in the following cycle
        cpu_halted = 1'b1;
        cpu_out    = 8'h3C;
        do_cmd(16'h0008, 1'b1, 32'h0, 32'h0000_3C01);
        reset = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_kill_vld", 32'(pio_rd_vld), 32'(0));
        idle(3);
        check("rst_cpu_reset_again", 32'(cpu_reset), 32'(1));
        do_cmd(16'h0008, 1'b1, 32'h0, 32'h0000_3C01);
        idle(4);
        check("sb_drained", 32'(sb_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
